hazard_stall_controller: RTL and testbench

// - Issue-stage sequencer between instruction fetch and DependencyCheckBlock: accepts 24-bit instructions,

---
 rtl/mips24_pkg.sv | 32 +++
 rtl/hazard_detect_unit.sv | 23 ++
 rtl/hazard_stall_controller.sv | 127 ++++++++++++
 tb/tb_hazard_stall_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips24_pkg.sv
// Shared definitions for the 24-bit issue path: opcodes, instruction field ranges,
// the register-read classification helper and the issue-sequencer state encoding.
package mips24_pkg;

   localparam logic [4:0]  OP_LOAD  = 5'b10100;
   localparam logic [4:0]  OP_STORE = 5'b10101;
   localparam logic [4:0]  OP_NOP   = 5'b11111;
   localparam logic [23:0] NOP_INS  = 24'hF80000;

   localparam int OP_HI  = 23;
   localparam int OP_LO  = 19;
   localparam int RD_HI  = 18;
   localparam int RD_LO  = 14;
   localparam int RS1_HI = 13;
   localparam int RS1_LO = 9;
   localparam int RS2_HI = 8;
   localparam int RS2_LO = 4;
   localparam int IMM_HI = 7;
   localparam int IMM_LO = 0;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } state_e;

   // Loads and the immediate class (op[3] set) carry no second source register.
   function automatic logic uses_rs2(input logic [4:0] op);
      return !((op == OP_LOAD) || op[3]);
   endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard compare: the incoming instruction reads the register that the
// load currently in ex will write, which forwarding cannot supply in time.
module hazard_detect_unit (
   input  logic [4:0] op_i,
   input  logic [4:0] rs1_i,
   input  logic [4:0] rs2_i,
   input  logic [4:0] ex_rd_i,
   input  logic       ex_is_load_i,
   input  logic       ins_valid_i,
   output logic       hazard_o
);
   import mips24_pkg::*;

   logic rs1_match;
   logic rs2_match;

   always_comb begin
      rs1_match = (rs1_i == ex_rd_i);
      rs2_match = uses_rs2(op_i) && (rs2_i == ex_rd_i);
      hazard_o  = ins_valid_i && ex_is_load_i && (ex_rd_i != 5'd0) && (rs1_match || rs2_match);
   end

endmodule

// File: rtl/hazard_stall_controller.sv
// Issue-stage sequencer: registers accepted instructions toward dependency check, inserts
// load-use bubbles, squashes on flush and keeps a saturating count of hazard bubbles.
module hazard_stall_controller #(
   parameter int LOAD_USE_STALL = 1,
   parameter int FLUSH_CYCLES   = 2,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [23:0]      ins_in,
   input  logic             ins_valid,
   output logic             ins_ready,
   input  logic             flush,
   output logic [23:0]      ins_out,
   output logic             ins_out_valid,
   output logic             bubble,
   output logic [CNT_W-1:0] stall_cycles
);
   import mips24_pkg::*;

   localparam logic [1:0]       STALL_RELOAD = 2'(LOAD_USE_STALL - 1);
   localparam logic [1:0]       FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

   state_e           state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [23:0]      ins_out_q, ins_out_d;
   logic             out_valid_q, out_valid_d;
   logic             bubble_q, bubble_d;
   logic [4:0]       ex_rd_q, ex_rd_d;
   logic             ex_is_load_q, ex_is_load_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             hazard;
   logic             count_bubble;

   hazard_detect_unit u_hazard_detect (
      .op_i         (ins_in[OP_HI:OP_LO]),
      .rs1_i        (ins_in[RS1_HI:RS1_LO]),
      .rs2_i        (ins_in[RS2_HI:RS2_LO]),
      .ex_rd_i      (ex_rd_q),
      .ex_is_load_i (ex_is_load_q),
      .ins_valid_i  (ins_valid),
      .hazard_o     (hazard)
   );

   assign ins_ready = (state_q == RUN) && !hazard && !flush;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ins_out_d    = NOP_INS;
      out_valid_d  = 1'b0;
      bubble_d     = 1'b0;
      count_bubble = 1'b0;
      case (state_q)
         RUN: begin
            if (flush) begin
               state_d = FLUSH;
               cnt_d   = FLUSH_RELOAD;
            end else if (hazard) begin
               bubble_d     = 1'b1;
               count_bubble = 1'b1;
               if (LOAD_USE_STALL > 1) begin
                  state_d = STALL;
                  cnt_d   = STALL_RELOAD;
               end
            end else if (ins_valid) begin
               ins_out_d   = ins_in;
               out_valid_d = 1'b1;
            end
         end
         STALL: begin
            if (flush) begin
               state_d = FLUSH;
               cnt_d   = FLUSH_RELOAD;
            end else begin
               bubble_d     = 1'b1;
               count_bubble = 1'b1;
               if (cnt_q == 2'd0) state_d = RUN;
               else               cnt_d   = cnt_q - 2'd1;
            end
         end
         FLUSH: begin
            // A new flush while squashing restarts the full squash window.
            if (flush)              cnt_d   = FLUSH_RELOAD;
            else if (cnt_q == 2'd0) state_d = RUN;
            else                    cnt_d   = cnt_q - 2'd1;
         end
         default: begin
            state_d = RUN;
            cnt_d   = 2'd0;
         end
      endcase

      ex_rd_d      = out_valid_d ? ins_out_d[RD_HI:RD_LO] : 5'd0;
      ex_is_load_d = out_valid_d && (ins_out_d[OP_HI:OP_LO] == OP_LOAD);
      stall_cnt_d  = (count_bubble && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= RUN;
         cnt_q        <= 2'd0;
         ins_out_q    <= NOP_INS;
         out_valid_q  <= 1'b0;
         bubble_q     <= 1'b0;
         ex_rd_q      <= 5'd0;
         ex_is_load_q <= 1'b0;
         stall_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         ins_out_q    <= ins_out_d;
         out_valid_q  <= out_valid_d;
         bubble_q     <= bubble_d;
         ex_rd_q      <= ex_rd_d;
         ex_is_load_q <= ex_is_load_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign ins_out       = ins_out_q;
   assign ins_out_valid = out_valid_q;
   assign bubble        = bubble_q;
   assign stall_cycles  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: two controller instances (default parameters, and a long-stall
// instance with a 2-bit counter) checked every cycle against a behavioural model.
module tb_hazard_stall_controller;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n [2];
   logic        vld   [2];
   logic        fl    [2];
   logic [23:0] ins   [2];
   logic        rdy   [2];
   logic [23:0] o     [2];
   logic        ov    [2];
   logic        ob    [2];
   logic [15:0] sc0;
   logic [1:0]  sc1;

   int checks   = 0;
   int failures = 0;

   hazard_stall_controller dut (
      .clk(clk), .reset(rst_n[0]), .ins_in(ins[0]), .ins_valid(vld[0]), .ins_ready(rdy[0]),
      .flush(fl[0]), .ins_out(o[0]), .ins_out_valid(ov[0]), .bubble(ob[0]), .stall_cycles(sc0)
   );

   hazard_stall_controller #(.LOAD_USE_STALL(3), .FLUSH_CYCLES(3), .CNT_W(2)) dut_s (
      .clk(clk), .reset(rst_n[1]), .ins_in(ins[1]), .ins_valid(vld[1]), .ins_ready(rdy[1]),
      .flush(fl[1]), .ins_out(o[1]), .ins_out_valid(ov[1]), .bubble(ob[1]), .stall_cycles(sc1)
   );

   // Behavioural model: remaining squash/stall cycles as plain counts, ex taken from the last output.
   int          L_p    [2] = '{1, 3};
   int          F_p    [2] = '{2, 3};
   int          sc_max [2] = '{65535, 3};
   int          m_stall_left [2];
   int          m_flush_left [2];
   logic [23:0] m_out [2];
   logic        m_v   [2];
   logic        m_b   [2];
   int          m_sc  [2];
   bit          m_known [2] = '{0, 0};

   function automatic bit m_hazard(input int k);
      logic [4:0] op, rs1, rs2, rd;
      bit         reads_rs2;
      op  = ins[k][23:19];
      rs1 = ins[k][13:9];
      rs2 = ins[k][8:4];
      rd  = m_out[k][18:14];
      if (!vld[k] || !m_v[k] || m_out[k][23:19] != 5'b10100 || rd == 5'd0) return 0;
      reads_rs2 = !(op == 5'b10100 || op[3]);
      return (rs1 == rd) || (reads_rs2 && rs2 == rd);
   endfunction

   function automatic bit m_ready(input int k);
      return m_stall_left[k] == 0 && m_flush_left[k] == 0 && !m_hazard(k) && !fl[k];
   endfunction

   task automatic m_step(input int k);
      bit hz;
      if (!rst_n[k]) begin
         m_out[k] = 24'hF80000; m_v[k] = 0; m_b[k] = 0; m_sc[k] = 0;
         m_stall_left[k] = 0; m_flush_left[k] = 0; m_known[k] = 1;
      end else if (m_known[k]) begin
         hz = m_hazard(k);
         m_out[k] = 24'hF80000; m_v[k] = 0; m_b[k] = 0;
         if (m_flush_left[k] > 0) begin
            if (fl[k]) m_flush_left[k] = F_p[k];
            else       m_flush_left[k]--;
         end else if (m_stall_left[k] > 0) begin
            if (fl[k]) begin
               m_stall_left[k] = 0; m_flush_left[k] = F_p[k];
            end else begin
               m_b[k] = 1; m_stall_left[k]--;
               if (m_sc[k] < sc_max[k]) m_sc[k]++;
            end
         end else if (fl[k]) begin
            m_flush_left[k] = F_p[k];
         end else if (hz) begin
            m_b[k] = 1;
            if (m_sc[k] < sc_max[k]) m_sc[k]++;
            m_stall_left[k] = (L_p[k] > 1) ? L_p[k] : 0;
         end else if (vld[k]) begin
            m_out[k] = ins[k]; m_v[k] = 1;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      m_step(0);
      m_step(1);
   end

   task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d got=%h exp=%h at %0t", nm, k, act, exp, $time);
      end
   endtask

   // Registered outputs just after the edge, ins_ready just after inputs change.
   initial forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (m_known[k]) begin
            check("ins_out", k, 32'(o[k]), 32'(m_out[k]));
            check("ins_out_valid", k, 32'(ov[k]), 32'(m_v[k]));
            check("bubble", k, 32'(ob[k]), 32'(m_b[k]));
            check("valid_and_bubble", k, 32'(ov[k] & ob[k]), 32'd0);
            check("stall_cycles", k, (k == 0) ? 32'(sc0) : 32'(sc1), 32'(m_sc[k]));
         end
      end
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++)
         if (m_known[k] && rst_n[k]) check("ins_ready", k, 32'(rdy[k]), 32'(m_ready(k)));
   end

   // Called at a negedge; holds the instruction until accepted, returns edges taken.
   task automatic send(input int k, input logic [23:0] val, input logic fl_in, output int edges);
      bit acc;
      bit got;
      got = 0;
      edges = 0;
      ins[k] = val; vld[k] = 1; fl[k] = fl_in;
      for (int n = 0; n < 20 && !got; n++) begin
         #1;
         acc = rdy[k];
         @(posedge clk);
         @(negedge clk);
         edges++;
         fl[k] = 0;
         if (acc) got = 1;
      end
      vld[k] = 0;
      if (!got) begin
         checks++; failures++;
         $display("FAIL accept_timeout dut%0d got=none exp=accepted ins=%h", k, val);
      end
      $display("tx dut%0d ins=%h flush=%0d edges=%0d out=%h valid=%0d", k, val, fl_in, edges, o[k], ov[k]);
   endtask

   localparam logic [23:0] LD4  = 24'hA10200;
   localparam logic [23:0] ADD4 = 24'h010800;

   initial begin
      int e;
      logic [23:0] v;
      for (int k = 0; k < 2; k++) begin
         rst_n[k] = 0; vld[k] = 1; fl[k] = 0; ins[k] = ADD4;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_ins_out", 0, 32'(o[0]), 32'hF80000);
      check("reset_valid", 0, 32'(ov[0]), 32'd0);
      check("reset_stall_cycles", 0, 32'(sc0), 32'd0);
      rst_n[0] = 1; rst_n[1] = 1;
      #1;
      check("ready_after_reset", 0, 32'(rdy[0]), 32'd1);
      vld[0] = 0; vld[1] = 0;
      @(negedge clk);

      // Independent stream
      send(0, 24'h004230, 0, e);
      check("lit_issue1", 0, 32'(o[0]), 32'h004230);
      send(0, 24'h21A000, 0, e);
      check("lit_issue2_edges", 0, 32'(e), 32'd1);
      check("lit_issue2", 0, 32'(o[0]), 32'h21A000);

      // Load-use on rs1: one bubble
      send(0, LD4, 0, e);
      send(0, ADD4, 0, e);
      check("lit_loaduse_edges", 0, 32'(e), 32'd2);
      check("lit_loaduse_out", 0, 32'(o[0]), 32'h010800);
      check("lit_loaduse_count", 0, 32'(sc0), 32'd1);

      // Register 0 never hazards
      send(0, {5'b10100, 5'd0, 5'd3, 5'd0, 4'd0}, 0, e);
      send(0, {5'b00000, 5'd5, 5'd0, 5'd0, 4'd0}, 0, e);
      check("lit_r0_edges", 0, 32'(e), 32'd1);

      // Immediate class ignores the rs2 field
      send(0, LD4, 0, e);
      send(0, {5'b01101, 5'd2, 5'd1, 5'd4, 4'd0}, 0, e);
      check("lit_imm_edges", 0, 32'(e), 32'd1);

      // Store reads rs2
      send(0, LD4, 0, e);
      send(0, {5'b10101, 5'd0, 5'd1, 5'd4, 4'd0}, 0, e);
      check("lit_store_edges", 0, 32'(e), 32'd2);
      check("lit_store_count", 0, 32'(sc0), 32'd2);

      // Flush together with a load-use hazard
      send(0, LD4, 0, e);
      send(0, ADD4, 1, e);
      check("lit_flush_out", 0, 32'(o[0]), 32'h010800);
      check("lit_flush_count", 0, 32'(sc0), 32'd2);
      check("lit_flush_delayed", 0, 32'(e > 2), 32'd1);

      // Flush re-asserted while squashing
      fl[0] = 1; @(negedge clk);
      fl[0] = 1; @(negedge clk);
      fl[0] = 0; repeat (5) @(negedge clk);
      send(0, 24'h004230, 0, e);
      check("lit_after_reflush", 0, 32'(e), 32'd1);

      // Long stall saturates the 2-bit counter
      send(1, LD4, 0, e);
      send(1, ADD4, 0, e);
      check("lit_sat_first", 1, 32'(sc1), 32'd3);
      check("lit_sat_out", 1, 32'(o[1]), 32'h010800);
      send(1, LD4, 0, e);
      send(1, ADD4, 0, e);
      check("lit_sat_hold", 1, 32'(sc1), 32'd3);

      // Flush abandons a stall
      send(1, LD4, 0, e);
      ins[1] = ADD4; vld[1] = 1;
      repeat (2) @(negedge clk);
      fl[1] = 1; @(negedge clk);
      fl[1] = 0;
      send(1, ADD4, 0, e);

      // Reset in the middle of a stall
      send(1, LD4, 0, e);
      ins[1] = ADD4; vld[1] = 1;
      repeat (2) @(negedge clk);
      rst_n[1] = 0; @(negedge clk);
      rst_n[1] = 1;
      check("lit_midreset_count", 1, 32'(sc1), 32'd0);
      check("lit_midreset_valid", 1, 32'(ov[1]), 32'd0);
      v = ADD4;
      send(1, v, 0, e);
      check("lit_midreset_edges", 1, 32'(e), 32'd1);
      check("lit_midreset_out", 1, 32'(o[1]), 32'h010800);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
